toy_mext_sched: RTL and testbench

- Issue scheduler in front of the M-extension execute unit. It shares the single mext issue port between NUM_REQ issue-queue requesters.
- Arbitrates round-robin among eligible requesters. A writeback-slot reservation vector guarantees that a MUL and a DIV never complete in the same cycle.
- Drives the unit's valid/payload, honours the unit's ready, flushes on cancel, and reports in-flight occupancy to rename/commit.

---
 rtl/toy_pack.sv | 43 ++++
 rtl/toy_mext_sched_chk.sv | 47 ++++
 rtl/toy_rr_arb.sv | 45 ++++
 rtl/toy_mext_sched.sv | 176 +++++++++++++++++
 tb/tb_toy_mext_sched.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/toy_pack.sv
// -----------------------------------------------------------------------------
// toy_pack
// Shared definitions for the M-extension issue path. Anything that has to agree
// with the mext execute unit lives here: the forwarded payload layout, the
// funct3 encodings, the pipeline depths and the instruction field macro.
//
// Contents:
//   INST_FIELD_FUNCT3(inst) - funct3 field of a 32-bit RISC-V instruction
//   MUL_STAGES / DIV_STAGES - issue-to-writeback depth (issue cycle = stage 0)
//   F3_*                    - M-extension funct3 encodings
//   forward_pkg             - payload forwarded from issue queue to the unit
//   f3_is_div()             - true for DIV/DIVU/REM/REMU
// -----------------------------------------------------------------------------
`ifndef TOY_PACK_INST_FIELDS
`define TOY_PACK_INST_FIELDS
`define INST_FIELD_FUNCT3(inst) inst[14:12]
`endif

package toy_pack;

  localparam int MUL_STAGES = 3;
  localparam int DIV_STAGES = 8;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef struct packed {
    logic [3:0]  rob_tag;
    logic [31:0] inst_pld;
  } forward_pkg;

  // Divider-class ops are exactly the encodings with funct3[2] set.
  function automatic logic f3_is_div(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

// File: rtl/toy_mext_sched_chk.sv
// -----------------------------------------------------------------------------
// toy_mext_sched_chk
// Invariant checker for toy_mext_sched. Holds no state; only watches the
// scheduler's grant, reservation and counter signals each clock.
//
// Ports:
//   i_clk, i_rst, i_cancel_en     clock, reset, flush (checks paused on rst)
//   i_set_vec [DIV_STAGES-1:0]    reservation bits claimed this cycle
//   i_res_mul, i_res_div          reservation bits probed by MUL / DIV grants
//   i_gnt_vld, i_gnt_div          grant this cycle and its class
//   i_req_rdy [NUM_REQ-1:0]       per-requester accept
//   i_cnt [CNT_W-1:0], i_wb_en    in-flight count and completion pulse
// -----------------------------------------------------------------------------
module toy_mext_sched_chk
  import toy_pack::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = $clog2(DIV_STAGES + 1)
) (
  input logic                  i_clk,
  input logic                  i_rst,
  input logic                  i_cancel_en,
  input logic [DIV_STAGES-1:0] i_set_vec,
  input logic                  i_res_mul,
  input logic                  i_res_div,
  input logic                  i_gnt_vld,
  input logic                  i_gnt_div,
  input logic [NUM_REQ-1:0]    i_req_rdy,
  input logic [CNT_W-1:0]      i_cnt,
  input logic                  i_wb_en
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_STAGES);

  // Sample the scheduler invariants once per clock outside reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      a_set_onehot0: assert ($onehot0(i_set_vec));
      a_rdy_onehot0: assert ($onehot0(i_req_rdy));
      a_mul_slot:    assert (!(i_gnt_vld && !i_gnt_div && i_res_mul));
      a_div_slot:    assert (!(i_gnt_vld && i_gnt_div && i_res_div));
      a_cnt_sat:     assert (i_cancel_en || !(i_gnt_vld && !i_wb_en && (i_cnt == CNT_MAX)));
      a_cnt_undf:    assert (i_cancel_en || !(i_wb_en && !i_gnt_vld && (i_cnt == '0)));
    end
  end

endmodule

// File: rtl/toy_rr_arb.sv
// -----------------------------------------------------------------------------
// toy_rr_arb
// Round-robin arbiter. Scans the request vector starting at i_ptr, wrapping
// around, and grants the first asserted request. The caller owns the pointer,
// so the arbiter itself is purely combinational and reusable.
//
// Ports:
//   i_req     [NUM_REQ-1:0] request vector
//   i_ptr     [IDX_W-1:0]   highest-priority index this cycle (< NUM_REQ)
//   o_gnt     [NUM_REQ-1:0] one-hot grant, zero when nothing requests
//   o_gnt_idx [IDX_W-1:0]   index of the granted request
//   o_gnt_vld               some request was granted
// -----------------------------------------------------------------------------
module toy_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_gnt_vld
);

  logic [IDX_W-1:0] w_idx;

  // Priority scan from the pointer; the first hit wins and later hits are ignored.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    w_idx     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_idx = IDX_W'((int'(i_ptr) + off) % NUM_REQ);
      if (!o_gnt_vld && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
        o_gnt_vld    = 1'b1;
      end else begin
        o_gnt_vld = o_gnt_vld;
      end
    end
  end

endmodule

// File: rtl/toy_mext_sched.sv
// -----------------------------------------------------------------------------
// toy_mext_sched
// Issue scheduler for the shared M-extension execute unit. Picks one of
// NUM_REQ issue-queue requesters per cycle (round-robin), issues it to the unit
// in the same cycle, and keeps a writeback reservation vector so that a MUL and
// a DIV never complete together. Reports in-flight occupancy.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_req_vld [NUM_REQ-1:0]      requester valid
//   o_req_rdy [NUM_REQ-1:0]      requester accept (one-hot or zero)
//   i_req_pld [NUM_REQ-1:0]      requester payloads
//   i_cancel_en                  pipeline flush
//   o_mext_vld / i_mext_rdy      issue handshake to the unit
//   o_mext_pld                   granted payload, zero when not issuing
//   i_mext_wb_en                 one completion this cycle
//   o_inflight_cnt [CNT_W-1:0]   issued but not yet completed
//   o_sched_idle                 nothing in flight and no requester valid
// -----------------------------------------------------------------------------
module toy_mext_sched
  import toy_pack::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = $clog2(DIV_STAGES + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_vld,
  output logic [NUM_REQ-1:0]        o_req_rdy,
  input  forward_pkg [NUM_REQ-1:0]  i_req_pld,
  input  logic                      i_cancel_en,
  output logic                      o_mext_vld,
  input  logic                      i_mext_rdy,
  output forward_pkg                o_mext_pld,
  input  logic                      i_mext_wb_en,
  output logic [CNT_W-1:0]          o_inflight_cnt,
  output logic                      o_sched_idle
);

  localparam int               IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_STAGES);

  // Bit k set: the writeback port is already claimed k cycles from now.
  logic [DIV_STAGES-1:0] r_res;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [CNT_W-1:0]      r_cnt;

  logic [2:0]            w_funct3 [NUM_REQ];
  logic [NUM_REQ-1:0]    w_is_div;
  logic [NUM_REQ-1:0]    w_elig;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_gnt_vld;
  logic                  w_gnt_div;
  logic [DIV_STAGES-1:0] w_set_vec;
  logic [IDX_W-1:0]      w_ptr_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;

  // Classify each request and decide whether its writeback slot is free.
  // Reset is folded in so nothing issues during the reset cycle.
  always_comb begin
    w_is_div = '0;
    w_elig   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_funct3[i] = `INST_FIELD_FUNCT3(i_req_pld[i].inst_pld);
      w_is_div[i] = f3_is_div(w_funct3[i]);
      w_elig[i]   = i_req_vld[i] & i_mext_rdy & ~i_cancel_en & ~i_rst &
                    (w_is_div[i] ? ~r_res[DIV_STAGES-1] : ~r_res[MUL_STAGES-1]);
    end
  end

  toy_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req     (w_elig),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  // Drive the issue port and claim the writeback slot of the granted op.
  always_comb begin
    o_req_rdy  = w_gnt;
    o_mext_vld = w_gnt_vld;
    o_mext_pld = '0;
    w_gnt_div  = 1'b0;
    w_set_vec  = '0;
    if (w_gnt_vld) begin
      o_mext_pld = i_req_pld[w_gnt_idx];
      w_gnt_div  = w_is_div[w_gnt_idx];
      if (w_gnt_div) begin
        w_set_vec[DIV_STAGES-1] = 1'b1;
      end else begin
        w_set_vec[MUL_STAGES-1] = 1'b1;
      end
    end else begin
      o_mext_pld = '0;
    end
  end

  // Pointer moves just past the winner so it gets lowest priority next time.
  always_comb begin
    if (w_gnt_idx == IDX_W'(NUM_REQ - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_gnt_idx + IDX_W'(1);
    end
  end

  // In-flight counter update: saturate at the deepest pipeline, hold at zero on underflow.
  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_gnt_vld, i_mext_wb_en})
      2'b10: begin
        if (r_cnt == CNT_MAX) begin
          w_cnt_nxt = r_cnt;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      2'b01: begin
        if (r_cnt == '0) begin
          w_cnt_nxt = r_cnt;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Scheduler state: reservations age by one each cycle; a flush drops every
  // reservation and the count but keeps the fairness pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_res    <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_cancel_en) begin
      r_res    <= '0;
      r_rr_ptr <= r_rr_ptr;
      r_cnt    <= '0;
    end else begin
      r_res <= (r_res | w_set_vec) >> 1'b1;
      r_cnt <= w_cnt_nxt;
      if (w_gnt_vld) begin
        r_rr_ptr <= w_ptr_nxt;
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
    end
  end

  assign o_inflight_cnt = r_cnt;
  assign o_sched_idle   = i_rst | ((r_cnt == '0) & ~(|i_req_vld));

  toy_mext_sched_chk #(
    .NUM_REQ (NUM_REQ),
    .CNT_W   (CNT_W)
  ) u_chk (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cancel_en (i_cancel_en),
    .i_set_vec   (w_set_vec),
    .i_res_mul   (r_res[MUL_STAGES-1]),
    .i_res_div   (r_res[DIV_STAGES-1]),
    .i_gnt_vld   (w_gnt_vld),
    .i_gnt_div   (w_gnt_div),
    .i_req_rdy   (o_req_rdy),
    .i_cnt       (r_cnt),
    .i_wb_en     (i_mext_wb_en)
  );

endmodule

// File: tb/tb_toy_mext_sched.sv
// -----------------------------------------------------------------------------
// tb_toy_mext_sched
// Per-cycle vector table for the main scenarios (single MUL, DIV/MUL writeback
// collision, alternating grants, issue stall, flush, mid-stream reset) plus a
// hand-written collision sequence that schedules completions from observed
// grants and checks that no two land in the same cycle.
// -----------------------------------------------------------------------------
module tb_toy_mext_sched;
  import toy_pack::*;

  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_vld;
  logic [NUM_REQ-1:0]       req_rdy;
  forward_pkg [NUM_REQ-1:0] req_pld;
  logic                     cancel_en;
  logic                     mext_vld;
  logic                     mext_rdy;
  forward_pkg               mext_pld;
  logic                     mext_wb_en;
  logic [CNT_W-1:0]         inflight_cnt;
  logic                     sched_idle;

  always #5 clk = ~clk;

  toy_mext_sched #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_vld      (req_vld),
    .o_req_rdy      (req_rdy),
    .i_req_pld      (req_pld),
    .i_cancel_en    (cancel_en),
    .o_mext_vld     (mext_vld),
    .i_mext_rdy     (mext_rdy),
    .o_mext_pld     (mext_pld),
    .i_mext_wb_en   (mext_wb_en),
    .o_inflight_cnt (inflight_cnt),
    .o_sched_idle   (sched_idle)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       rst;
    logic [1:0] vld;
    logic [1:0] div;
    logic       cancel;
    logic       mrdy;
    logic       wb;
    logic [1:0] e_rdy;
    logic       e_idle;
    logic [3:0] e_cnt;
    logic [7:0] e_res;
    logic       e_ptr;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r, input logic [1:0] vl, input logic [1:0] dv,
                   input logic cn, input logic mr, input logic wb,
                   input logic [1:0] er, input logic ei, input logic [3:0] ec,
                   input logic [7:0] es, input logic ep);
    vec_t t;
    t.rst = r; t.vld = vl; t.div = dv; t.cancel = cn; t.mrdy = mr; t.wb = wb;
    t.e_rdy = er; t.e_idle = ei; t.e_cnt = ec; t.e_res = es; t.e_ptr = ep;
    vecs.push_back(t);
  endtask

  function automatic forward_pkg mk_pld(input int idx, input logic is_div);
    forward_pkg p;
    p.rob_tag  = 4'(idx + 1);
    p.inst_pld = 32'h0200_0033 | (32'(idx + 1) << 7) | (is_div ? 32'h0000_4000 : 32'h0000_0000);
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] vl, input logic [1:0] dv,
                       input logic cn, input logic mr, input logic wb);
    rst        = r;
    req_vld    = vl;
    req_pld[0] = mk_pld(0, dv[0]);
    req_pld[1] = mk_pld(1, dv[1]);
    cancel_en  = cn;
    mext_rdy   = mr;
    mext_wb_en = wb;
  endtask

  initial begin : main
    forward_pkg e_pld;
    int         wb_sched [0:31];
    int         wb_max;
    logic [1:0] e_rdy;

    // rst vld div cn mrdy wb | rdy idle cnt res ptr
    // Single MUL on req0
    v(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 4'd0, 8'h00, 1'b0);
    v(1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 4'd0, 8'h00, 1'b0);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd1, 8'h02, 1'b1);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 4'd1, 8'h01, 1'b1);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 4'd0, 8'h00, 1'b1);
    // DIV on req0, MUL on req1 held from cycle 5 (collision at 5)
    v(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 4'd0, 8'h00, 1'b1);
    v(1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 4'd0, 8'h00, 1'b0);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd1, 8'h40, 1'b1);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd1, 8'h20, 1'b1);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd1, 8'h10, 1'b1);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd1, 8'h08, 1'b1);
    v(1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd1, 8'h04, 1'b1);
    v(1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 4'd1, 8'h02, 1'b1);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 4'd2, 8'h03, 1'b0);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 4'd1, 8'h01, 1'b0);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 4'd0, 8'h00, 1'b0);
    // Both requesters hold MUL for 6 cycles
    v(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 4'd0, 8'h00, 1'b0);
    v(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 4'd0, 8'h00, 1'b0);
    v(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 4'd1, 8'h02, 1'b1);
    v(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 4'd2, 8'h03, 1'b0);
    v(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 4'd2, 8'h03, 1'b1);
    v(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 4'd2, 8'h03, 1'b0);
    v(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 4'd2, 8'h03, 1'b1);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 4'd2, 8'h03, 1'b0);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 4'd1, 8'h01, 1'b0);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 4'd0, 8'h00, 1'b0);
    // mext_rdy low on cycles 2-3
    v(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 4'd0, 8'h00, 1'b0);
    v(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 4'd0, 8'h00, 1'b0);
    v(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 4'd1, 8'h02, 1'b1);
    v(1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'd2, 8'h03, 1'b0);
    v(1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'd1, 8'h01, 1'b0);
    v(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 4'd0, 8'h00, 1'b0);
    v(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 4'd1, 8'h02, 1'b1);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 4'd2, 8'h03, 1'b0);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 4'd1, 8'h01, 1'b0);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 4'd0, 8'h00, 1'b0);
    // 3 DIVs in flight, cancel at cycle 4 (wb ignored), reset at cycle 6
    v(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 4'd0, 8'h00, 1'b0);
    v(1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 4'd0, 8'h00, 1'b0);
    v(1'b0, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 4'd1, 8'h40, 1'b1);
    v(1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 4'd2, 8'h60, 1'b0);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd3, 8'h70, 1'b1);
    v(1'b0, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 4'd3, 8'h38, 1'b1);
    v(1'b0, 2'b01, 2'b11, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 4'd0, 8'h00, 1'b1);
    v(1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 4'd1, 8'h40, 1'b1);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 4'd0, 8'h00, 1'b0);
    v(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 4'd0, 8'h00, 1'b0);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd1, 8'h02, 1'b1);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 4'd1, 8'h01, 1'b1);
    v(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 4'd0, 8'h00, 1'b1);

    drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);

    for (int r = 0; r < vecs.size(); r++) begin
      @(posedge clk);
      #1;
      drive(vecs[r].rst, vecs[r].vld, vecs[r].div, vecs[r].cancel, vecs[r].mrdy, vecs[r].wb);
      @(negedge clk);
      if (vecs[r].e_rdy[0]) e_pld = mk_pld(0, vecs[r].div[0]);
      else if (vecs[r].e_rdy[1]) e_pld = mk_pld(1, vecs[r].div[1]);
      else e_pld = '0;
      chk($sformatf("row%0d req_rdy", r),  64'(req_rdy),        64'(vecs[r].e_rdy));
      chk($sformatf("row%0d mext_vld", r), 64'(mext_vld),       64'(|vecs[r].e_rdy));
      chk($sformatf("row%0d mext_pld", r), 64'(mext_pld),       64'(e_pld));
      chk($sformatf("row%0d cnt", r),      64'(inflight_cnt),   64'(vecs[r].e_cnt));
      chk($sformatf("row%0d idle", r),     64'(sched_idle),     64'(vecs[r].e_idle));
      chk($sformatf("row%0d res", r),      64'(dut.r_res),      64'(vecs[r].e_res));
      chk($sformatf("row%0d rr_ptr", r),   64'(dut.r_rr_ptr),   64'(vecs[r].e_ptr));
    end

    // Collision sequence: DIV on req0 at cycle 0, req1 offers MUL on cycles 1-7.
    // Completions are scheduled from the grants actually seen.
    for (int k = 0; k < 32; k++) wb_sched[k] = 0;
    @(posedge clk);
    #1;
    drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk);
      #1;
      drive(1'b0,
            (cyc == 0) ? 2'b01 : ((cyc <= 7) ? 2'b10 : 2'b00),
            (cyc == 0) ? 2'b01 : 2'b00,
            1'b0, 1'b1, (wb_sched[cyc] != 0));
      @(negedge clk);
      if (cyc == 0) e_rdy = 2'b01;
      else if (cyc == 5) e_rdy = 2'b00;
      else if (cyc <= 7) e_rdy = 2'b10;
      else e_rdy = 2'b00;
      chk($sformatf("coll cyc%0d req_rdy", cyc), 64'(req_rdy), 64'(e_rdy));
      if (req_rdy[0]) wb_sched[cyc + DIV_STAGES - 1]++;
      if (req_rdy[1]) wb_sched[cyc + MUL_STAGES - 1]++;
    end
    wb_max = 0;
    for (int k = 0; k < 32; k++) if (wb_sched[k] > wb_max) wb_max = wb_sched[k];
    chk("coll max wb per cycle", 64'(wb_max), 64'(1));
    chk("coll final cnt", 64'(inflight_cnt), 64'(0));
    chk("coll final idle", 64'(sched_idle), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
